// File: rtl/lane_game_pkg.sv
// Shared state encoding and default parameter constants for the lane game core.
package lane_game_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_HIT  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   localparam int DEF_COLS      = 20;
   localparam int DEF_ROWS      = 15;
   localparam int DEF_LIVES     = 3;
   localparam int DEF_WIN_SCORE = 10;
   localparam int DEF_HIT_HOLD  = 8;

   // Odd rows rotate toward higher columns, even rows toward lower columns.
   localparam logic [63:0] DEF_LANE_DIR = {32{2'b10}};

endpackage

// File: rtl/lane_game_core_lane_row.sv
// One rotating obstacle lane: loads its initial pattern, rotates one column per enable.
module lane_row #(
   parameter int W   = 20,
   parameter bit DIR = 1'b1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] init,
   output logic [W-1:0] row
);

   logic [W-1:0] row_q;
   logic [W-1:0] row_d;

   // Next lane contents: reload wins over rotation; DIR=1 moves bits toward higher columns.
   always_comb begin
      // NOTE: row_d gets a default first so every path assigns it and no latch is inferred.
      row_d = row_q;
      if (load) begin
         row_d = init;
      end else if (en) begin
         row_d = DIR ? {row_q[W-2:0], row_q[W-1]} : {row_q[0], row_q[W-1:1]};
      end
   end

   // Lane register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: the lane bits are plain flops, not a RAM, so reset can legally restore the whole pattern.
      if (!reset) begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         row_q <= init;
      end else begin
         row_q <= row_d;
      end
   end

   assign row = row_q;

endmodule

// File: rtl/lane_game_core.sv
// Lane-crossing game core: rotating obstacle lanes, player movement, scoring and lives.
module lane_game_core
   import lane_game_pkg::*;
#(
   parameter int                      COLS      = DEF_COLS,
   parameter int                      ROWS      = DEF_ROWS,
   parameter logic [COLS*ROWS-1:0]    LANE_INIT = '0,
   parameter logic [ROWS-1:0]         LANE_DIR  = DEF_LANE_DIR[ROWS-1:0],
   parameter int                      LIVES     = DEF_LIVES,
   parameter int                      WIN_SCORE = DEF_WIN_SCORE,
   parameter int                      HIT_HOLD  = DEF_HIT_HOLD,
   localparam int                     XW        = $clog2(COLS),
   localparam int                     YW        = $clog2(ROWS)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          lane_tick,
   input  logic          move_tick,
   input  logic          btn_up,
   input  logic          btn_down,
   input  logic          btn_left,
   input  logic          btn_right,
   input  logic [XW-1:0] qx,
   input  logic [YW-1:0] qy,
   output logic          q_obstacle,
   output logic          q_player,
   output logic [XW-1:0] player_x,
   output logic [YW-1:0] player_y,
   output logic [3:0]    lives,
   output logic [3:0]    score,
   output logic [1:0]    state,
   output logic          collision
);

   localparam int              HW        = $clog2(HIT_HOLD + 1);
   localparam logic [XW-1:0]   X_MAX     = XW'(COLS - 1);
   localparam logic [XW-1:0]   X_START   = XW'(COLS / 2);
   localparam logic [XW-1:0]   X_ONE     = XW'(1);
   localparam logic [YW-1:0]   Y_MAX     = YW'(ROWS - 1);
   localparam logic [YW-1:0]   Y_ONE     = YW'(1);
   localparam logic [YW-1:0]   Y_PRE     = YW'(ROWS - 2);
   localparam logic [3:0]      LIVES_4   = 4'(LIVES);
   localparam logic [3:0]      WIN_4     = 4'(WIN_SCORE);
   localparam logic [HW-1:0]   HOLD_LAST = HW'(HIT_HOLD - 1);

   state_e        state_q, state_d;
   logic [XW-1:0] player_x_q, player_x_d;
   logic [YW-1:0] player_y_q, player_y_d;
   logic [3:0]    score_q, score_d;
   logic [3:0]    lives_q, lives_d;
   logic [HW-1:0] hold_q, hold_d;
   logic          collision_q, collision_d;
   logic          start_q;

   logic          start_rise;
   logic          lane_load;
   logic          lane_en;
   logic          hit_here;
   logic          go_up, go_down, go_left, go_right;
   logic [COLS-1:0] lane_map [ROWS];

   assign start_rise = start & ~start_q;
   assign lane_en    = lane_tick & ((state_q == ST_PLAY) | (state_q == ST_HIT));

   // Opposing buttons pressed together cancel their axis before priority is applied.
   assign go_up    = btn_up    & ~btn_down;
   assign go_down  = btn_down  & ~btn_up;
   assign go_left  = btn_left  & ~btn_right;
   assign go_right = btn_right & ~btn_left;

   // Start and goal rows are always empty; the rows in between are rotating lanes.
   for (genvar r = 0; r < ROWS; r++) begin : g_lane
      if (r == 0 || r == ROWS - 1) begin : g_fixed
         assign lane_map[r] = '0;
      end else begin : g_rot
         lane_row #(
            .W   (COLS),
            .DIR (LANE_DIR[r])
         ) u_row (
            .clk   (clk),
            .reset (reset),
            .load  (lane_load),
            .en    (lane_en),
            .init  (LANE_INIT[r*COLS +: COLS]),
            .row   (lane_map[r])
         );
      end
   end

   // Hit looks at registered lane and player state, so it lands one cycle after the causing tick.
   assign hit_here = lane_map[player_y_q][player_x_q];

   // Next-state, movement, scoring and lives.
   always_comb begin
      state_d     = state_q;
      player_x_d  = player_x_q;
      player_y_d  = player_y_q;
      score_d     = score_q;
      lives_d     = lives_q;
      hold_d      = hold_q;
      collision_d = 1'b0;
      lane_load   = 1'b0;

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_rise) begin
               state_d    = ST_PLAY;
               lane_load  = 1'b1;
               score_d    = 4'd0;
               lives_d    = LIVES_4;
               player_x_d = X_START;
               player_y_d = '0;
               hold_d     = '0;
            end
         end
         ST_PLAY: begin
            if (player_y_q == Y_MAX) begin
               // Goal takes precedence over any hit: return to start, finish on the winning crossing.
               player_x_d = X_START;
               player_y_d = '0;
               if (score_q == WIN_4) begin
                  state_d = ST_DONE;
               end
            end else if (hit_here) begin
               collision_d = 1'b1;
               lives_d     = (lives_q == 4'd0) ? 4'd0 : lives_q - 4'd1;
               player_x_d  = X_START;
               player_y_d  = '0;
               hold_d      = '0;
               state_d     = ST_HIT;
            end else if (move_tick) begin
               if (go_up) begin
                  player_y_d = player_y_q + Y_ONE;
                  if (player_y_q == Y_PRE) begin
                     score_d = score_q + 4'd1;
                  end
               end else if (go_down) begin
                  if (player_y_q != '0) begin
                     player_y_d = player_y_q - Y_ONE;
                  end
               end else if (go_left) begin
                  if (player_x_q != '0) begin
                     player_x_d = player_x_q - X_ONE;
                  end
               end else if (go_right) begin
                  if (player_x_q != X_MAX) begin
                     player_x_d = player_x_q + X_ONE;
                  end
               end
            end
         end
         ST_HIT: begin
            if (lives_q == 4'd0) begin
               state_d = ST_DONE;
            end else if (move_tick) begin
               if (hold_q == HOLD_LAST) begin
                  state_d = ST_PLAY;
                  hold_d  = '0;
               end else begin
                  hold_d = hold_q + HW'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State register with synchronous active-low reset that overrides all ticks.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         player_x_q  <= X_START;
         player_y_q  <= '0;
         score_q     <= 4'd0;
         lives_q     <= LIVES_4;
         hold_q      <= '0;
         collision_q <= 1'b0;
         start_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         player_x_q  <= player_x_d;
         player_y_q  <= player_y_d;
         score_q     <= score_d;
         lives_q     <= lives_d;
         hold_q      <= hold_d;
         collision_q <= collision_d;
         start_q     <= start;
      end
   end

   // Zero-latency pixel query; coordinates outside the field read as empty.
   assign q_obstacle = (qx <= X_MAX && qy <= Y_MAX) ? lane_map[qy][qx] : 1'b0;
   assign q_player   = (qx == player_x_q) && (qy == player_y_q);

   assign player_x  = player_x_q;
   assign player_y  = player_y_q;
   assign lives     = lives_q;
   assign score     = score_q;
   assign state     = state_q;
   assign collision = collision_q;

endmodule

// File: tb/tb_lane_game_core.sv
// Directed bench for lane_game_core: reset, hit/HIT hold, edges, goal run, restart, reset mid-HIT.
module tb_lane_game_core;

   localparam int COLS = 20;
   localparam int ROWS = 15;
   localparam int XW   = $clog2(COLS);
   localparam int YW   = $clog2(ROWS);

   // Row 1 obstacle at column 10; stray bits in rows 0 and 14 must be ignored.
   localparam logic [COLS*ROWS-1:0] INIT =
      (300'(1) << (1*COLS + 10)) | (300'(1) << 5) | (300'(1) << (14*COLS + 2));

   logic          clk = 1'b0;
   logic          reset, start, lane_tick, move_tick;
   logic          btn_up, btn_down, btn_left, btn_right;
   logic [XW-1:0] qx;
   logic [YW-1:0] qy;

   logic          q_obstacle, q_player, collision;
   logic [XW-1:0] player_x;
   logic [YW-1:0] player_y;
   logic [3:0]    lives, score;
   logic [1:0]    state;

   logic          u1_q_obstacle, u1_q_player, u1_collision;
   logic [XW-1:0] u1_player_x;
   logic [YW-1:0] u1_player_y;
   logic [3:0]    u1_lives, u1_score;
   logic [1:0]    u1_state;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   lane_game_core #(.COLS(COLS), .ROWS(ROWS), .LANE_INIT(INIT)) u_dut (
      .clk(clk), .reset(reset), .start(start), .lane_tick(lane_tick), .move_tick(move_tick),
      .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
      .qx(qx), .qy(qy), .q_obstacle(q_obstacle), .q_player(q_player),
      .player_x(player_x), .player_y(player_y), .lives(lives), .score(score),
      .state(state), .collision(collision)
   );

   lane_game_core #(.COLS(COLS), .ROWS(ROWS), .LANE_INIT(INIT), .LIVES(1)) u_dut1 (
      .clk(clk), .reset(reset), .start(start), .lane_tick(lane_tick), .move_tick(move_tick),
      .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
      .qx(qx), .qy(qy), .q_obstacle(u1_q_obstacle), .q_player(u1_q_player),
      .player_x(u1_player_x), .player_y(u1_player_y), .lives(u1_lives), .score(u1_score),
      .state(u1_state), .collision(u1_collision)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mv();
      move_tick = 1'b1;
      tick();
      move_tick = 1'b0;
      tick();
   endtask

   task automatic qchk(input string tag, input int x, input int y, input logic exp);
      qx = XW'(x);
      qy = YW'(y);
      #1;
      check(tag, q_obstacle, exp);
   endtask

   task automatic btns(input logic u, input logic d, input logic l, input logic r);
      btn_up = u; btn_down = d; btn_left = l; btn_right = r;
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; lane_tick = 1'b0; move_tick = 1'b0;
      btns(0, 0, 0, 0);
      qx = '0; qy = '0;

      // Reset state
      tick(); tick();
      check("rst_state", state, 0);
      check("rst_x", player_x, 10);
      check("rst_y", player_y, 0);
      check("rst_lives", lives, 3);
      check("rst_score", score, 0);
      check("rst_coll", collision, 0);
      qchk("rst_obs_r1c10", 10, 1, 1'b1);
      qchk("rst_row0_empty", 5, 0, 1'b0);
      qchk("rst_row14_empty", 2, 14, 1'b0);
      qchk("q_out_of_range", 25, 1, 1'b0);
      qx = XW'(10); qy = YW'(0); #1;
      check("q_player_start", q_player, 1);

      // Lanes frozen in IDLE
      reset = 1'b1;
      tick();
      lane_tick = 1'b1; tick(); lane_tick = 1'b0; tick();
      qchk("idle_frozen_c10", 10, 1, 1'b1);
      qchk("idle_frozen_c11", 11, 1, 1'b0);

      // Start rise -> PLAY
      start = 1'b1;
      tick();
      check("play_state", state, 1);
      check("play_x", player_x, 10);
      check("play_y", player_y, 0);
      check("play_lives", lives, 3);
      check("play_score", score, 0);

      // Step up into the row 1 obstacle
      btns(1, 0, 0, 0); move_tick = 1'b1;
      tick();
      btns(0, 0, 0, 0); move_tick = 1'b0;
      check("up_y", player_y, 1);
      check("up_no_coll_yet", collision, 0);
      tick();
      check("hit_coll", collision, 1);
      check("hit_lives", lives, 2);
      check("hit_state", state, 2);
      check("hit_x", player_x, 10);
      check("hit_y", player_y, 0);
      check("l1_hit_state", u1_state, 2);
      check("l1_hit_lives", u1_lives, 0);
      tick();
      check("coll_pulse_end", collision, 0);
      check("still_hit", state, 2);
      check("l1_done", u1_state, 3);

      // HIT hold: 8 move_ticks, lanes rotate, buttons ignored
      btns(1, 0, 0, 0);
      lane_tick = 1'b1; move_tick = 1'b1; tick(); lane_tick = 1'b0; move_tick = 1'b0; tick();
      qchk("hit_rot_c11", 11, 1, 1'b1);
      qchk("hit_rot_c10", 10, 1, 1'b0);
      for (int i = 0; i < 6; i++) mv();
      check("hold7_state", state, 2);
      check("hold7_y", player_y, 0);
      mv();
      check("hold8_state", state, 1);
      btns(0, 0, 0, 0);

      // Edges and button priority
      btns(0, 1, 0, 0); mv();
      check("down_row0", player_y, 0);
      btns(0, 0, 1, 0);
      for (int i = 0; i < 10; i++) mv();
      check("left_to_0", player_x, 0);
      mv();
      check("left_sat", player_x, 0);
      btns(0, 0, 1, 1); mv();
      check("lr_cancel", player_x, 0);
      btns(1, 1, 0, 1); mv();
      check("ud_cancel_x", player_x, 1);
      check("ud_cancel_y", player_y, 0);
      btns(1, 0, 0, 1); mv();
      check("prio_up_x", player_x, 1);
      check("prio_up_y", player_y, 1);

      // First crossing from (1,1)
      btns(1, 0, 0, 0);
      for (int i = 0; i < 12; i++) mv();
      move_tick = 1'b1; tick(); move_tick = 1'b0;
      check("goal_y", player_y, 14);
      check("goal_score", score, 1);
      tick();
      check("goal_ret_x", player_x, 10);
      check("goal_ret_y", player_y, 0);
      check("goal_state", state, 1);

      // Nine more crossings to WIN_SCORE
      for (int c = 0; c < 9; c++) begin
         for (int i = 0; i < 14; i++) mv();
         check("cross_score", score, c + 2);
      end
      check("win_state", state, 3);
      check("win_y", player_y, 0);
      btns(0, 0, 0, 0);

      // DONE: lanes frozen, no movement
      lane_tick = 1'b1; tick(); tick(); lane_tick = 1'b0;
      btns(1, 0, 0, 0); mv(); btns(0, 0, 0, 0);
      qchk("done_frozen_c11", 11, 1, 1'b1);
      qchk("done_frozen_c12", 12, 1, 1'b0);
      check("done_no_move", player_y, 0);

      // Restart from DONE
      start = 1'b0; tick();
      start = 1'b1; tick();
      check("restart_state", state, 1);
      check("restart_lives", lives, 3);
      check("restart_score", score, 0);
      qchk("restart_reload", 10, 1, 1'b1);
      check("l1_restart_state", u1_state, 1);
      check("l1_restart_lives", u1_lives, 1);

      // Reset mid-HIT with both ticks asserted
      btns(1, 0, 0, 0); mv(); btns(0, 0, 0, 0);
      check("hit2_state", state, 2);
      check("hit2_coll", collision, 1);
      reset = 1'b0; lane_tick = 1'b1; move_tick = 1'b1;
      tick();
      lane_tick = 1'b0; move_tick = 1'b0;
      check("midrst_state", state, 0);
      check("midrst_coll", collision, 0);
      check("midrst_lives", lives, 3);
      check("midrst_y", player_y, 0);
      qchk("midrst_c10", 10, 1, 1'b1);
      qchk("midrst_c11", 11, 1, 1'b0);
      reset = 1'b1;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
